// File: rtl/wokwi_395522292785089537_pkg.sv
// Shared types and constants for the 8-bit accumulator/ALU tile.
// Holds the opcode encoding, the datapath width and the default parameter values.
package wokwi_395522292785089537_pkg;

    localparam int W = 8;

    localparam logic [W-1:0] RESET_VALUE_DEF = 8'h00;
    localparam logic [W-1:0] LFSR_TAPS_DEF   = 8'hB8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_XOR  = 3'b110,
        OP_LFSR = 3'b111
    } op_e;

endpackage

// File: rtl/wokwi_395522292785089537_alu.sv
// Next-accumulator function for one opcode; SATURATE_EN clamps ADD/SUB instead of wrapping.
// Latency: purely combinational.
// Backpressure: none, a result is produced for every input combination.
module wokwi_395522292785089537_alu
    import wokwi_395522292785089537_pkg::*;
#(
    parameter logic [W-1:0] LFSR_TAPS = LFSR_TAPS_DEF
) (
    input  op_e          op,
    input  logic [W-1:0] acc,
    input  logic [4:0]   opd,
    output logic [W-1:0] next_acc
);

    logic [W-1:0] opd_ext;
    logic [W-1:0] add_res;
    logic [W-1:0] sub_res;
    logic [W-1:0] lfsr_res;

    assign opd_ext = {3'b000, opd};

`ifdef SATURATE_EN
    logic [W:0] sum;
    logic [W:0] diff;

    assign sum     = {1'b0, acc} + {1'b0, opd_ext};
    assign diff    = {1'b0, acc} - {1'b0, opd_ext};
    // The extra MSB is the carry on ADD and the borrow on SUB.
    assign add_res = sum[W]  ? {W{1'b1}} : sum[W-1:0];
    assign sub_res = diff[W] ? {W{1'b0}} : diff[W-1:0];
`else
    assign add_res = acc + opd_ext;
    assign sub_res = acc - opd_ext;
`endif

    // Zero is a lock-up state for the Galois register, so it is kicked to 1.
    assign lfsr_res = (acc == '0) ? 8'h01
                    : ((acc >> 1) ^ (acc[0] ? LFSR_TAPS : {W{1'b0}}));

    always_comb begin
        next_acc = acc;
        unique case (op)
            OP_NOP:  next_acc = acc;
            OP_LOAD: next_acc = opd_ext;
            OP_ADD:  next_acc = add_res;
            OP_SUB:  next_acc = sub_res;
            OP_SHL:  next_acc = {acc[W-2:0], opd[0]};
            OP_SHR:  next_acc = {opd[0], acc[W-1:1]};
            OP_XOR:  next_acc = acc ^ opd_ext;
            OP_LFSR: next_acc = lfsr_res;
            default: next_acc = acc;
        endcase
    end

endmodule

// File: rtl/wokwi_395522292785089537.sv
// Registered 8-bit accumulator tile executing one ui_in opcode per clock (SATURATE_EN selects clamping ADD/SUB).
// Latency: 1 cycle from ui_in to uo_out, output driven straight from the register.
// Backpressure: none, an opcode is consumed every cycle.
module wokwi_395522292785089537
    import wokwi_395522292785089537_pkg::*;
#(
    parameter logic [W-1:0] RESET_VALUE = RESET_VALUE_DEF,
    parameter logic [W-1:0] LFSR_TAPS   = LFSR_TAPS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] ui_in,
    output logic [W-1:0] uo_out
);

    logic [W-1:0] acc;
    logic [W-1:0] next_acc;

    wokwi_395522292785089537_alu #(
        .LFSR_TAPS (LFSR_TAPS)
    ) u_alu (
        .op       (op_e'(ui_in[7:5])),
        .acc      (acc),
        .opd      (ui_in[4:0]),
        .next_acc (next_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= RESET_VALUE;
        end else begin
            acc <= next_acc;
        end
    end

    assign uo_out = acc;

endmodule

// File: tb/tb_wokwi_395522292785089537.sv
// Self-checking bench for the accumulator tile: directed scenarios plus a random run against a reference model.
module tb_wokwi_395522292785089537;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    wokwi_395522292785089537 dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uo_out (uo_out)
    );

    always #5 clk = ~clk;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Drive one cycle of stimulus and return with outputs settled after the edge.
    task automatic apply(input logic r, input logic [7:0] u);
        @(negedge clk);
        rst   = r;
        ui_in = u;
        @(posedge clk);
        #1;
    endtask

    // Independent reference written from the opcode table.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] u);
        logic [7:0] o;
        int         t;
        o = {3'b000, u[4:0]};
        case (u[7:5])
            3'd0: return a;
            3'd1: return o;
            3'd2: begin
                t = int'(a) + int'(o);
                if (t > 255) return SAT ? 8'hFF : 8'(t - 256);
                return 8'(t);
            end
            3'd3: begin
                t = int'(a) - int'(o);
                if (t < 0) return SAT ? 8'h00 : 8'(t + 256);
                return 8'(t);
            end
            3'd4: return {a[6:0], u[0]};
            3'd5: return {u[0], a[7:1]};
            3'd6: return a ^ o;
            default: begin
                if (a == 8'h00) return 8'h01;
                if (a[0]) return (a >> 1) ^ 8'hB8;
                return a >> 1;
            end
        endcase
    endfunction

    task automatic test_reset();
        exp_q.push_back(8'h00);
        apply(1'b1, 8'h5F);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (uo_out !== exp_v) begin
            n_fail++;
            $display("FAIL reset_value: got %h expected %h", uo_out, exp_v);
        end
        exp_q.push_back(8'h1F);
        apply(1'b0, 8'h5F);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (uo_out !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release_add: got %h expected %h", uo_out, exp_v);
        end
    endtask

    task automatic test_load_add_nop();
        logic [7:0] stim[3] = '{8'h25, 8'h5F, 8'h00};
        logic [7:0] expv[3] = '{8'h05, 8'h24, 8'h24};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(expv[i]);
            apply(1'b0, stim[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (uo_out !== exp_v) begin
                n_fail++;
                $display("FAIL load_add_nop[%0d]: got %h expected %h", i, uo_out, exp_v);
            end
        end
    endtask

    task automatic test_wrap_saturate();
        logic [7:0] stim[7] = '{8'h20, 8'h61, 8'h3F, 8'h81, 8'h81, 8'h81, 8'h41};
        logic [7:0] expv[7];
        expv = '{8'h00, SAT ? 8'h00 : 8'hFF, 8'h1F, 8'h3F, 8'h7F, 8'hFF, SAT ? 8'hFF : 8'h00};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(expv[i]);
            apply(1'b0, stim[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (uo_out !== exp_v) begin
                n_fail++;
                $display("FAIL wrap_saturate[%0d]: got %h expected %h", i, uo_out, exp_v);
            end
        end
    endtask

    task automatic test_lfsr();
        logic [7:0] stim[4] = '{8'h20, 8'hE0, 8'hE0, 8'hE0};
        logic [7:0] expv[4] = '{8'h00, 8'h01, 8'hB8, 8'h5C};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(expv[i]);
            apply(1'b0, stim[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (uo_out !== exp_v) begin
                n_fail++;
                $display("FAIL lfsr[%0d]: got %h expected %h", i, uo_out, exp_v);
            end
        end
    endtask

    task automatic test_shift_xor();
        logic [7:0] stim[4] = '{8'h31, 8'hA1, 8'h80, 8'hDF};
        logic [7:0] expv[4] = '{8'h11, 8'h88, 8'h10, 8'h0F};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(expv[i]);
            apply(1'b0, stim[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (uo_out !== exp_v) begin
                n_fail++;
                $display("FAIL shift_xor[%0d]: got %h expected %h", i, uo_out, exp_v);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic       rv[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] stim[6] = '{8'h20, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0};
        logic [7:0] expv[6] = '{8'h00, 8'h01, 8'hB8, 8'h00, 8'h01, 8'hB8};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(expv[i]);
            apply(rv[i], stim[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (uo_out !== exp_v) begin
                n_fail++;
                $display("FAIL mid_reset[%0d]: got %h expected %h", i, uo_out, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] m;
        logic [7:0] u;
        logic       r;
        exp_q.push_back(8'h00);
        apply(1'b1, 8'hFF);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (uo_out !== exp_v) begin
            n_fail++;
            $display("FAIL random_reset: got %h expected %h", uo_out, exp_v);
        end
        m = 8'h00;
        for (int i = 0; i < 400; i++) begin
            u = 8'($urandom_range(0, 255));
            r = ($urandom_range(0, 49) == 0);
            m = r ? 8'h00 : model(m, u);
            exp_q.push_back(m);
            apply(r, u);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (uo_out !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d] op=%h rst=%0d: got %h expected %h", i, u, r, uo_out, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_add_nop();
        test_wrap_saturate();
        test_lfsr();
        test_shift_xor();
        test_mid_reset();
        test_back_to_back_random();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
